// File: rtl/tt_um_divider4_if.sv
// Tile-side pin bundle for the 4-bit divider: operand/handshake inputs and result/status outputs.
// "master" drives operands and start; "slave" is the divider tile.
interface tt_um_divider4_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_divider4.sv
// Sequential unsigned restoring divider tile: one quotient bit per clock, MSB first,
// 4-phase start/done handshake on uio, quotient/remainder on uo_out.
module tt_um_divider4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_STEP = 2'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_dvd;        // dividend, shifts left; quotient bits enter at LSB
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;        // partial remainder
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_res_quo;
    logic [WIDTH-1:0] r_res_rem;
    logic             r_dbz;

    logic             w_start;
    logic [WIDTH-1:0] w_in_dvd;
    logic [WIDTH-1:0] w_in_dvs;
    logic             w_in_zero;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;
    logic             w_busy;
    logic             w_done;
    logic             w_unused;

    assign w_start   = uio_in[0];
    assign w_in_dvd  = ui_in[WIDTH-1:0];
    assign w_in_dvs  = ui_in[4 +: WIDTH];
    assign w_in_zero = (w_in_dvs == '0);

    // The partial remainder can have its MSB set, so the trial value keeps all of it
    // plus the incoming dividend bit (WIDTH+1 bits) before comparing to the divisor.
    assign w_trial    = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_dvs};
    assign w_qbit     = (w_trial >= {1'b0, r_dvs});
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], w_qbit};

    assign w_unused = &{1'b0, ena, uio_in, ui_in};

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE waits for start, RUN counts WIDTH steps, DONE waits for start low
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = w_in_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_STEP) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (!w_start) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake status decoded from state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand load in IDLE, one restoring step per RUN edge, result load on last step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_res_quo <= '0;
            r_res_rem <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_dvd <= w_in_dvd;
                        r_dvs <= w_in_dvs;
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_dbz <= w_in_zero;
                        if (w_in_zero) begin
                            r_res_quo <= '1;
                            r_res_rem <= w_in_dvd;
                        end
                    end
                end
                S_RUN: begin
                    r_dvd <= w_dvd_next;
                    r_rem <= w_rem_next;
                    r_cnt <= 2'(r_cnt + 2'd1);
                    if (r_cnt == LAST_STEP) begin
                        r_res_quo <= w_dvd_next;
                        r_res_rem <= w_rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uo_out  = {4'(r_res_rem), 4'(r_res_quo)};
    assign uio_out = {4'b0000, r_dbz, w_done, w_busy, 1'b0};
    assign uio_oe  = 8'b0000_1110;

endmodule

// File: tb/tb_tt_um_divider4.sv
// Self-checking bench for tt_um_divider4: directed vector table, handshake corner
// sequences, and an exhaustive operand sweep against an arithmetic reference.
module tb_tt_um_divider4;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tt_um_divider4_if bus ();

    tt_um_divider4 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (bus.ena),
        .ui_in   (bus.ui_in),
        .uio_in  (bus.uio_in),
        .uo_out  (bus.uo_out),
        .uio_out (bus.uio_out),
        .uio_oe  (bus.uio_oe)
    );

    logic busy, done, dbz;
    assign busy = bus.uio_out[1];
    assign done = bus.uio_out[2];
    assign dbz  = bus.uio_out[3];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] prev_uo;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uo;
        bit         dbz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division; divide-by-zero gives all-ones quotient, remainder = dividend
    function automatic logic [7:0] ref_uo(input logic [7:0] ui);
        int a = int'(ui[3:0]);
        int b = int'(ui[7:4]);
        if (b == 0) return {ui[3:0], 4'hF};
        return {4'(a % b), 4'(a / b)};
    endfunction

    // One full 4-phase transaction with latency, status, stability and invariant checks
    task automatic do_div(input logic [7:0] ui, input logic [7:0] exp_uo, input bit exp_dbz,
                          input bit scramble, input string tag);
        int lat   = 0;
        int nbusy = 0;
        bit stable  = 1'b1;
        bit overlap = 1'b0;
        int qa, qb, qq, qr;
        bus.ui_in  = ui;
        bus.uio_in = 8'h01;
        tick;
        lat = 1;
        if (scramble) bus.ui_in = 8'($urandom);
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            if (busy && done) overlap = 1'b1;
            if (bus.uo_out !== prev_uo) stable = 1'b0;
            tick;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_dbz ? 1 : W + 1);
        chk({tag, " busy_cycles"}, nbusy, exp_dbz ? 0 : W);
        chk({tag, " uo_stable_in_run"}, stable, 1);
        chk({tag, " busy_done_overlap"}, overlap, 0);
        chk({tag, " uo_out"}, bus.uo_out, exp_uo);
        chk({tag, " div_by_zero"}, dbz, exp_dbz);
        chk({tag, " busy_at_done"}, busy, 0);
        if (!exp_dbz) begin
            qa = int'(ui[3:0]);
            qb = int'(ui[7:4]);
            qq = int'(bus.uo_out[3:0]);
            qr = int'(bus.uo_out[7:4]);
            chk({tag, " inv_qbr"}, qq * qb + qr, qa);
            chk({tag, " inv_r_lt_b"}, qr < qb, 1);
        end
        prev_uo    = exp_uo;
        bus.uio_in = 8'h00;
        tick;
        chk({tag, " idle_status"}, bus.uio_out[2:1], 0);
        chk({tag, " idle_hold_uo"}, bus.uo_out, exp_uo);
        chk({tag, " idle_hold_dbz"}, dbz, exp_dbz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   nb;
        int   nd;

        vecs = '{
            '{8'h3D, 8'h14, 1'b0},
            '{8'h1F, 8'h0F, 1'b0},
            '{8'h70, 8'h00, 1'b0},
            '{8'h53, 8'h30, 1'b0},
            '{8'h09, 8'h9F, 1'b1},
            '{8'h3D, 8'h14, 1'b0},
            '{8'hFF, 8'h01, 1'b0},
            '{8'h0F, 8'hFF, 1'b1},
            '{8'hE1, 8'h10, 1'b0},
            '{8'h2F, 8'h17, 1'b0}
        };

        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        rst_n      = 1'b0;
        prev_uo    = 8'h00;
        tick;
        tick;
        rst_n = 1'b1;
        chk("reset uo_out", bus.uo_out, 8'h00);
        chk("reset uio_out", bus.uio_out, 8'h00);
        chk("uio_oe", bus.uio_oe, 8'h0E);

        foreach (vecs[i]) begin
            do_div(vecs[i].ui, vecs[i].uo, vecs[i].dbz, 1'b0, $sformatf("vec%0d", i));
        end

        // start held high: exactly one run, done holds, then release to IDLE
        bus.ui_in  = 8'h3D;
        bus.uio_in = 8'h01;
        tick;
        bus.ui_in = 8'hA5;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) nb++;
            if (done) nd++;
            tick;
        end
        chk("hold busy_cycles", nb, 4);
        chk("hold done_cycles", nd, 16);
        chk("hold done_still", done, 1);
        chk("hold uo_out", bus.uo_out, 8'h14);
        bus.uio_in = 8'h00;
        tick;
        chk("release status", bus.uio_out[2:1], 0);
        chk("release uo_out", bus.uo_out, 8'h14);
        tick;
        chk("idle no_start uo_out", bus.uo_out, 8'h14);
        chk("idle no_start status", bus.uio_out, 8'h00);
        prev_uo = 8'h14;

        // reset mid-run at E2
        bus.ui_in  = 8'h3D;
        bus.uio_in = 8'h01;
        tick;
        tick;
        rst_n      = 1'b0;
        bus.uio_in = 8'h00;
        tick;
        chk("midrst uo_out", bus.uo_out, 8'h00);
        chk("midrst uio_out", bus.uio_out, 8'h00);
        rst_n   = 1'b1;
        prev_uo = 8'h00;
        tick;
        chk("post_rst idle", bus.uio_out, 8'h00);
        do_div(8'h3D, 8'h14, 1'b0, 1'b0, "post_rst");

        // exhaustive sweep, random idle gaps, operands scrambled during RUN
        for (int k = 0; k < 256; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            do_div(8'(k), ref_uo(8'(k)), (k[7:4] == 4'd0), 1'b1, $sformatf("sweep%02h", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
